// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: control-unit, memory and instruction-register
// signals of the two-byte instruction fetch sequencer.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 16
);
    // control unit side
    logic              Start;
    logic              PCLoad;
    logic [ADDR_W-1:0] PCIn;
    logic              Busy;
    logic              Done;
    logic              Error;
    logic [ADDR_W-1:0] PC;

    // byte-wide memory side
    logic              MemRead;
    logic [ADDR_W-1:0] MemAddr;
    logic [7:0]        MemData;
    logic              MemValid;

    // instruction register side
    logic [7:0]        IRData;
    logic              IRWrite;
    logic              IRLH;

    modport master (
        input  Start,
        input  PCLoad,
        input  PCIn,
        input  MemData,
        input  MemValid,
        output MemRead,
        output MemAddr,
        output IRData,
        output IRWrite,
        output IRLH,
        output PC,
        output Busy,
        output Done,
        output Error
    );

    modport slave (
        output Start,
        output PCLoad,
        output PCIn,
        output MemData,
        output MemValid,
        input  MemRead,
        input  MemAddr,
        input  IRData,
        input  IRWrite,
        input  IRLH,
        input  PC,
        input  Busy,
        input  Done,
        input  Error
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches a 16-bit instruction as two bytes (PC, PC+1).
// Optional request timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input logic               Clock_i,
    input logic               ResetN_i,
    fetch_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_LO = 3'd1,
        WR_LO  = 3'd2,
        REQ_HI = 3'd3,
        WR_HI  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        ird_q, ird_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              lh_q, lh_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tmo;
    logic              in_req;

    assign in_req = (state_q == REQ_LO) || (state_q == REQ_HI);

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // abort when this waiting cycle would bring the count up to TIMEOUT;
    // a MemValid in that same cycle still completes the byte
    assign tmo = in_req
              && !bus.MemValid
              && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT;
    assign tmo            = 1'b0;
`endif

    // state and registered outputs
    always_ff @(posedge Clock_i or negedge ResetN_i) begin
        if (!ResetN_i) begin
            state_q <= IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            ird_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            lh_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ird_q   <= ird_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            lh_q    <= lh_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // next-state sequencing through the two byte transfers
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.Start) state_d = REQ_LO;
            end
            REQ_LO: begin
                if (bus.MemValid) state_d = WR_LO;
                else if (tmo)     state_d = IDLE;
            end
            WR_LO: begin
                state_d = REQ_HI;
            end
            REQ_HI: begin
                if (bus.MemValid) state_d = WR_HI;
                else if (tmo)     state_d = IDLE;
            end
            WR_HI: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // next values of PC, memory request and IR write controls
    always_comb begin
        pc_d   = pc_q;
        addr_d = addr_q;
        ird_d  = ird_q;
        lh_d   = lh_q;
        rd_d   = rd_q;
        wr_d   = 1'b0;
        done_d = 1'b0;
        busy_d = (state_d != IDLE);
`ifdef FETCH_TIMEOUT_EN
        cnt_d  = cnt_q;
        err_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.PCLoad) pc_d = bus.PCIn;
                if (bus.Start) begin
                    rd_d   = 1'b1;
                    addr_d = bus.PCLoad ? bus.PCIn : pc_q;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d  = '0;
`endif
                end
            end
            REQ_LO, REQ_HI: begin
                if (bus.MemValid) begin
                    ird_d = bus.MemData;
                    lh_d  = (state_q == REQ_HI);
                    wr_d  = 1'b1;
                    pc_d  = pc_q + ADDR_W'(1);
                    rd_d  = 1'b0;
                end else if (tmo) begin
                    rd_d  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    err_d = 1'b1;
`endif
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            WR_LO: begin
                rd_d   = 1'b1;
                addr_d = pc_q;
`ifdef FETCH_TIMEOUT_EN
                cnt_d  = '0;
`endif
            end
            WR_HI: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.PC      = pc_q;
    assign bus.MemAddr = addr_q;
    assign bus.MemRead = rd_q;
    assign bus.IRData  = ird_q;
    assign bus.IRWrite = wr_q;
    assign bus.IRLH    = lh_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
`ifdef FETCH_TIMEOUT_EN
    assign bus.Error   = err_q;
`else
    assign bus.Error   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized fetches against a byte-memory model,
// scoreboard of expected addresses, IR writes, Done/Error events.
module tb_fetch_sequencer;
    localparam int AW = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(AW)) bus ();

    fetch_sequencer #(
        .ADDR_W  (AW),
        .TIMEOUT (15)
    ) dut (
        .Clock_i  (clk),
        .ResetN_i (rstn),
        .bus      (bus.master)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [7:0]    mem [0:65535];
    logic [AW-1:0] mpc;

    logic [AW-1:0] aq[$];
    logic [8:0]    wq[$];
    logic [AW-1:0] dpcq[$];
    int            dcycq[$];
    int            ecycq[$];
    int            waitq[$];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
    endtask

    always @(posedge clk) cyc++;

    // memory: answers each request after a queued number of wait cycles,
    // throws spurious MemValid pulses when no request is pending
    int rcnt = 0;
    bit ract = 1'b0;
    always @(negedge clk) begin
        if (!rstn || !bus.MemRead) begin
            ract         = 1'b0;
            bus.MemValid = ($urandom_range(3) == 0);
            bus.MemData  = 8'($urandom);
        end else begin
            if (!ract) begin
                ract = 1'b1;
                rcnt = (waitq.size() > 0) ? waitq.pop_front() : 0;
            end
            if (rcnt == 0) begin
                bus.MemValid = 1'b1;
                bus.MemData  = mem[bus.MemAddr];
            end else begin
                rcnt--;
                bus.MemValid = 1'b0;
                bus.MemData  = 8'($urandom);
            end
        end
    end

    // monitor: compares every DUT event against the scoreboard
    logic          rd_prev = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.MemRead) begin
                if (!rd_prev) begin
                    if (aq.size() == 0) flag("mem_req");
                    else begin
                        cur_addr = aq.pop_front();
                        chk("req_addr", 32'(bus.MemAddr), 32'(cur_addr));
                    end
                end else begin
                    chk("addr_hold", 32'(bus.MemAddr), 32'(cur_addr));
                end
            end
            if (bus.IRWrite) begin
                if (wq.size() == 0) flag("ir_write");
                else chk("ir_byte", 32'({bus.IRLH, bus.IRData}),
                         32'(wq.pop_front()));
            end
            if (bus.Done) begin
                if (dpcq.size() == 0) flag("done");
                else begin
                    chk("done_pc", 32'(bus.PC), 32'(dpcq.pop_front()));
                    chk("done_cycle", cyc, dcycq.pop_front());
                end
            end
            if (bus.Error) begin
                if (ecycq.size() == 0) flag("error");
                else begin
                    chk("err_cycle", cyc, ecycq.pop_front());
                    chk("err_rd", 32'(bus.MemRead), 0);
                    chk("err_busy", 32'(bus.Busy), 0);
                end
            end
            rd_prev = bus.MemRead;
        end else begin
            rd_prev = 1'b0;
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_rd"},   32'(bus.MemRead), 0);
        chk({tag, "_addr"}, 32'(bus.MemAddr), 0);
        chk({tag, "_ird"},  32'(bus.IRData),  0);
        chk({tag, "_wr"},   32'(bus.IRWrite), 0);
        chk({tag, "_lh"},   32'(bus.IRLH),    0);
        chk({tag, "_pc"},   32'(bus.PC),      0);
        chk({tag, "_busy"}, 32'(bus.Busy),    0);
        chk({tag, "_done"}, 32'(bus.Done),    0);
        chk({tag, "_err"},  32'(bus.Error),   0);
    endtask

    // wait out a busy period while throwing ignored Start/PCLoad at it
    task automatic ride_busy();
        int k;
        k = 0;
        while (bus.Busy && k < 200) begin
            bus.Start  = 1'($urandom);
            bus.PCLoad = 1'($urandom);
            bus.PCIn   = AW'($urandom);
            @(negedge clk);
            k++;
        end
        bus.Start  = 1'b0;
        bus.PCLoad = 1'b0;
        if (k >= 200) chk("busy_timeout", 32'(bus.Busy), 0);
    endtask

    // one fetch issued from IDLE at a negedge
    task automatic do_fetch(input bit ld, input logic [AW-1:0] pin,
                            input int w0, input int w1, input bit abort);
        logic [AW-1:0] a1;
        int            n;
        n = cyc;
        if (ld) mpc = pin;
        a1 = mpc + AW'(1);
        aq.push_back(mpc);
        if (abort) begin
            waitq.push_back(100000);
            ecycq.push_back(n + 16);
        end else begin
            aq.push_back(a1);
            waitq.push_back(w0);
            waitq.push_back(w1);
            wq.push_back({1'b0, mem[mpc]});
            wq.push_back({1'b1, mem[a1]});
            mpc = mpc + AW'(2);
            dpcq.push_back(mpc);
            dcycq.push_back(n + 5 + w0 + w1);
        end
        bus.Start  = 1'b1;
        bus.PCLoad = ld;
        bus.PCIn   = pin;
        @(negedge clk);
        ride_busy();
    endtask

    task automatic do_load(input logic [AW-1:0] pin);
        bus.PCLoad = 1'b1;
        bus.PCIn   = pin;
        mpc        = pin;
        @(negedge clk);
        bus.PCLoad = 1'b0;
        chk("pc_load", 32'(bus.PC), 32'(mpc));
    endtask

    task automatic reset_mid_fetch();
        int k;
        mpc = 16'h0300;
        aq.push_back(mpc);
        waitq.push_back(1);
        wq.push_back({1'b0, mem[mpc]});
        bus.Start  = 1'b1;
        bus.PCLoad = 1'b1;
        bus.PCIn   = 16'h0300;
        @(negedge clk);
        bus.Start  = 1'b0;
        bus.PCLoad = 1'b0;
        k = 0;
        while (!bus.IRWrite && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("wr_lo_seen", 32'(bus.IRWrite), 1);
        #2 rstn = 1'b0;
        #1 chk_zero("rst_mid");
        aq.delete();
        wq.delete();
        waitq.delete();
        mpc = '0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        chk("pc_after_rst", 32'(bus.PC), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.Start  = 1'b0;
        bus.PCLoad = 1'b0;
        bus.PCIn   = '0;
        mpc        = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0040] = 8'h34;
        mem[16'h0041] = 8'h12;

        #1 chk_zero("reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        do_fetch(1'b1, 16'h0040, 0, 0, 1'b0);
        chk("pc_basic", 32'(bus.PC), 32'h0042);
        do_fetch(1'b0, '0, 3, 3, 1'b0);
        do_fetch(1'b1, 16'hFFFF, 0, 0, 1'b0);
        chk("pc_wrap", 32'(bus.PC), 32'h0001);
        reset_mid_fetch();

`ifdef FETCH_TIMEOUT_EN
        do_fetch(1'b1, 16'h0200, 0, 0, 1'b1);
        chk("pc_abort", 32'(bus.PC), 32'h0200);
        do_fetch(1'b0, '0, 1, 0, 1'b0);
`endif

        for (int it = 0; it < 150; it++) begin
            int            r;
            logic [AW-1:0] p;
            r = $urandom_range(9);
            p = AW'($urandom);
            if (r == 0) p = 16'hFFFF;
            if (r == 1) p = 16'hFFFE;
            if (r < 2) begin
                do_load(p);
            end else begin
                do_fetch(1'($urandom), p,
                         $urandom_range(5), $urandom_range(5), 1'b0);
            end
        end

        repeat (5) @(negedge clk);
        chk("aq_empty", aq.size(), 0);
        chk("wq_empty", wq.size(), 0);
        chk("dq_empty", dpcq.size(), 0);
        chk("eq_empty", ecycq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
